// File: rtl/ascon_pkg.sv
// Shared Ascon types, round-constant schedule and sequencer FSM encoding.
package ascon_pkg;

    localparam int unsigned ASCON_WORD_W     = 64;
    localparam int unsigned ASCON_NUM_WORDS  = 5;
    localparam int unsigned ASCON_MAX_ROUNDS = 16;
    localparam int unsigned ASCON_RC_W       = 8;
    localparam int unsigned ASCON_IDX_W      = 4;
    localparam int unsigned ASCON_RND_W      = 5;

    typedef logic [ASCON_WORD_W-1:0] ascon_word_t;
    typedef ascon_word_t [ASCON_NUM_WORDS-1:0] ascon_state_t;
    typedef logic [ASCON_RC_W-1:0] ascon_rc_t;

    // Index i holds the constant for round i of the full 16-round schedule.
    localparam ascon_rc_t ASCON_RC [ASCON_MAX_ROUNDS] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ascon_perm_fsm_e;

    function automatic ascon_word_t ror(input ascon_word_t x, input int unsigned n);
        return (x >> n) | (x << (ASCON_WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box, diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state,
    input  ascon_rc_t    rc,
    output ascon_state_t result
);

    ascon_state_t sbox_out;

    // Bit-sliced 5-bit S-box applied to all 64 columns at once.
    always_comb begin
        ascon_word_t x0, x1, x2, x3, x4;
        ascon_word_t t0, t1, t2, t3, t4;
        x0 = state[0];
        x1 = state[1];
        x2 = state[2] ^ ascon_word_t'(rc);
        x3 = state[3];
        x4 = state[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        sbox_out = '{x4, x3, x2, x1, x0};
    end

    linear_diffusion_layer u_ldl (
        .state  (sbox_out),
        .result (result)
    );

endmodule

// File: rtl/linear_diffusion_layer.sv
// Ascon linear diffusion: each word XORed with two rotations of itself.
module linear_diffusion_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state,
    output ascon_state_t result
);

    assign result[0] = state[0] ^ ror(state[0], 19) ^ ror(state[0], 28);
    assign result[1] = state[1] ^ ror(state[1], 61) ^ ror(state[1], 39);
    assign result[2] = state[2] ^ ror(state[2],  1) ^ ror(state[2],  6);
    assign result[3] = state[3] ^ ror(state[3], 10) ^ ror(state[3], 17);
    assign result[4] = state[4] ^ ror(state[4],  7) ^ ror(state[4], 41);

endmodule

// File: rtl/ascon_permutation_seq.sv
// Iterative Ascon-p[rnd] sequencer: one round per clock between two valid/ready handshakes.
module ascon_permutation_seq
    import ascon_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  ascon_state_t           state_i,
    input  logic [ASCON_RND_W-1:0] rounds_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output ascon_state_t           state_o,
    output logic                   busy_o
);

    localparam logic [ASCON_IDX_W-1:0] IDX_LAST = ASCON_IDX_W'(ASCON_MAX_ROUNDS - 1);
    localparam logic [ASCON_RND_W-1:0] RND_MAX  = ASCON_RND_W'(ASCON_MAX_ROUNDS);

    ascon_perm_fsm_e        fsm_q, fsm_d;
    ascon_state_t           state_q, state_d, round_state;
    logic [ASCON_IDX_W-1:0] idx_q, idx_d;
    logic [ASCON_RND_W-1:0] rnd_q, rnd_d, rnd_sat;

    assign rnd_sat = (rounds_i > RND_MAX) ? RND_MAX : rounds_i;

    ascon_round u_round (
        .state  (state_q),
        .rc     (ASCON_RC[idx_q]),
        .result (round_state)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
        end
    end

    // Index starts at 16-r so the last round always lands on index 15.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        unique case (fsm_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = state_i;
                    rnd_d   = rnd_sat;
                    idx_d   = ASCON_IDX_W'(RND_MAX - rnd_sat);
                    fsm_d   = (rnd_sat == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_d = round_state;
                if (idx_q == IDX_LAST) begin
                    fsm_d = DONE;
                end else begin
                    idx_d = idx_q + ASCON_IDX_W'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign ready_o = (fsm_q == IDLE);
    assign valid_o = (fsm_q == DONE);
    assign busy_o  = (fsm_q != IDLE);
    assign state_o = state_q;

    a_run_has_rounds: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fsm_q == RUN) |-> (rnd_q != '0));

endmodule
